// File: rtl/conv_tile_sched.sv
// Tile sequencer for the conv/ReLU/avg-pool datapath: raster walk, read, latency wait, capture, handshaked write.
// Optional CONV_SCHED_PERF_EN adds stall and accepted-tile counters.
module conv_tile_sched #(
  parameter int          RD_LAT   = 1,
  parameter int          CALC_LAT = 1,
  parameter logic [15:0] IN_BASE  = 16'h0000,
  parameter logic [15:0] OUT_BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cfg_tiles_x,
  input  logic [7:0]  cfg_tiles_y,
  output logic        busy,
  output logic        done,
  output logic        input_re,
  output logic [15:0] input_addr,
  output logic        cap_en,
  output logic        output_we,
  output logic [15:0] output_addr,
  input  logic        out_ready,
  output logic [7:0]  tile_x,
  output logic [7:0]  tile_y
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [15:0] perf_tiles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_RD, S_CALC, S_WRITE, S_DONE
  } state_t;

  localparam logic [15:0] RD_END   = 16'(RD_LAT - 1);
  localparam logic [15:0] CALC_END = 16'(CALC_LAT - 1);

  state_t      state, state_nxt;
  logic [7:0]  tx, ty;
  logic [15:0] idx;
  logic [15:0] cnt;
  logic        go, xfer, last_tile;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    input_re    = 1'b0;
    input_addr  = 16'h0000;
    cap_en      = 1'b0;
    output_we   = 1'b0;
    output_addr = 16'h0000;
    go          = 1'b0;
    xfer        = 1'b0;
    last_tile   = (tile_x == tx - 8'd1) && (tile_y == ty - 8'd1);
    case (state)
      S_IDLE: begin
        if (start) begin
          go        = (cfg_tiles_x != 8'd0) && (cfg_tiles_y != 8'd0);
          state_nxt = go ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        busy       = 1'b1;
        input_re   = 1'b1;
        input_addr = IN_BASE + idx;
        state_nxt  = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        busy = 1'b1;
        if (cnt == RD_END) state_nxt = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt == CALC_END) begin
          cap_en    = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        busy        = 1'b1;
        output_we   = 1'b1;
        output_addr = OUT_BASE + idx;
        if (out_ready) begin
          xfer      = 1'b1;
          state_nxt = last_tile ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tile walk: idx is a running count so addresses never need tile_y*tx
  always_ff @(posedge clk) begin
    if (rst) begin
      tx     <= 8'd0;
      ty     <= 8'd0;
      idx    <= 16'd0;
      tile_x <= 8'd0;
      tile_y <= 8'd0;
      cnt    <= 16'd0;
    end else begin
      if (go) begin
        tx     <= cfg_tiles_x;
        ty     <= cfg_tiles_y;
        idx    <= 16'd0;
        tile_x <= 8'd0;
        tile_y <= 8'd0;
      end else if (xfer && !last_tile) begin
        idx <= idx + 16'd1;
        if (tile_x == tx - 8'd1) begin
          tile_x <= 8'd0;
          tile_y <= tile_y + 8'd1;
        end else begin
          tile_x <= tile_x + 8'd1;
        end
      end
      if ((state_nxt == state) && ((state == S_WAIT_RD) || (state == S_CALC)))
        cnt <= cnt + 16'd1;
      else
        cnt <= 16'd0;
    end
  end

`ifdef CONV_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall <= 32'd0;
      perf_tiles <= 16'd0;
    end else if ((state == S_IDLE) && start) begin
      perf_stall <= 32'd0;
      perf_tiles <= 16'd0;
    end else begin
      if ((state == S_WRITE) && !out_ready && (perf_stall != 32'hFFFF_FFFF))
        perf_stall <= perf_stall + 32'd1;
      if (xfer)
        perf_tiles <= perf_tiles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_tile_sched.sv
// Scoreboard bench for conv_tile_sched: expected read/write addresses and done tokens are queued
// by the stimulus and consumed by a negedge monitor; a second instance covers long latencies.
module tb_conv_tile_sched;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [7:0]  cfg_tiles_x, cfg_tiles_y;
  logic        busy, done, input_re, cap_en, output_we;
  logic [15:0] input_addr, output_addr;
  logic [7:0]  tile_x, tile_y;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_stall, perf_stall5;
  logic [15:0] perf_tiles, perf_tiles5;
`endif

  logic        start5;
  logic        busy5, done5, input_re5, cap_en5, output_we5;
  logic [15:0] input_addr5, output_addr5;
  logic [7:0]  tile_x5, tile_y5;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_rd[$];
  logic [15:0] exp_wr[$];
  int exp_done = 0;

  always #5 clk = ~clk;

  conv_tile_sched u_dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_tiles_x(cfg_tiles_x), .cfg_tiles_y(cfg_tiles_y),
    .busy(busy), .done(done), .input_re(input_re), .input_addr(input_addr),
    .cap_en(cap_en), .output_we(output_we), .output_addr(output_addr),
    .out_ready(out_ready), .tile_x(tile_x), .tile_y(tile_y)
`ifdef CONV_SCHED_PERF_EN
    , .perf_stall(perf_stall), .perf_tiles(perf_tiles)
`endif
  );

  conv_tile_sched #(.RD_LAT(3), .CALC_LAT(2), .IN_BASE(16'hFFFF), .OUT_BASE(16'h1234)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5),
    .cfg_tiles_x(8'd1), .cfg_tiles_y(8'd1),
    .busy(busy5), .done(done5), .input_re(input_re5), .input_addr(input_addr5),
    .cap_en(cap_en5), .output_we(output_we5), .output_addr(output_addr5),
    .out_ready(1'b1), .tile_x(tile_x5), .tile_y(tile_y5)
`ifdef CONV_SCHED_PERF_EN
    , .perf_stall(perf_stall5), .perf_tiles(perf_tiles5)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Monitor: consume scoreboard entries whenever the DUT presents a read, write or done
  always @(negedge clk) begin
    if (input_re) begin
      if (exp_rd.size() == 0) check("unexpected_read", {16'h0, input_addr}, 32'hDEAD);
      else check("read_addr", {16'h0, input_addr}, {16'h0, exp_rd.pop_front()});
    end
    if (output_we && out_ready) begin
      if (exp_wr.size() == 0) check("unexpected_write", {16'h0, output_addr}, 32'hDEAD);
      else check("write_addr", {16'h0, output_addr}, {16'h0, exp_wr.pop_front()});
    end
    if (done) begin
      if (exp_done == 0) check("unexpected_done", 32'd1, 32'd0);
      else exp_done--;
    end
    if (cap_en) check("cap_we_overlap", {31'd0, output_we}, 32'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] x, input logic [7:0] y);
    tick();
    cfg_tiles_x = x;
    cfg_tiles_y = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cyc);
    busy_cyc = 0;
    for (int i = 0; i < 500; i++) begin
      if (done) return;
      if (busy) busy_cyc++;
      tick();
    end
    fail_now("wait_done");
  endtask

  task automatic push_run(input int n);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(16'(i));
      exp_wr.push_back(16'(i));
    end
    exp_done++;
  endtask

  initial begin
    int bc, hold, rd_during, re_c, cap_c, we_c;
    bit seen;
    rst = 1'b1; start = 1'b0; start5 = 1'b0; out_ready = 1'b1;
    cfg_tiles_x = 8'd0; cfg_tiles_y = 8'd0;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_re_we_cap", {29'd0, input_re, output_we, cap_en}, 32'd0);
    check("rst_addrs", {input_addr, output_addr}, 32'd0);
    check("rst_tile_xy", {16'd0, tile_x, tile_y}, 32'd0);
`ifdef CONV_SCHED_PERF_EN
    check("rst_perf", perf_stall | {16'd0, perf_tiles}, 32'd0);
`endif
    rst = 1'b0;

    // 2x3 grid, ready always high
    push_run(6);
    pulse_start(8'd2, 8'd3);
    wait_done(bc);
    check("t1_busy_cycles", bc, 32'd24);
    check("t1_last_tile_x", {24'd0, tile_x}, 32'd1);
    check("t1_last_tile_y", {24'd0, tile_y}, 32'd2);
    tick();
    check("t1_done_one_cycle", {30'd0, done, busy}, 32'd0);

    // 3x1 grid with 5 stall cycles on tile 1
    push_run(3);
    pulse_start(8'd3, 8'd1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (input_re && input_addr == 16'd1) seen = 1'b1;
      else tick();
    end
    if (!seen) fail_now("t2_fetch_tile1");
    out_ready = 1'b0;
    hold = 0; rd_during = 0;
    for (int i = 0; i < 100; i++) begin
      if (output_we) begin
        hold++;
        if (input_re) rd_during++;
        check("t2_held_addr", {16'd0, output_addr}, 32'd1);
        if (hold == 6) out_ready = 1'b1;
      end else if (hold > 0) begin
        break;
      end
      tick();
    end
    check("t2_hold_cycles", hold, 32'd6);
    check("t2_no_fetch_while_held", rd_during, 32'd0);
    check("t2_fetch_follows_accept", {15'd0, input_re, input_addr}, {15'd0, 1'b1, 16'd2});
    wait_done(bc);
    check("t2_tail_busy", bc, 32'd4);
`ifdef CONV_SCHED_PERF_EN
    tick(); tick();
    check("t6_perf_stall", perf_stall, 32'd5);
    check("t6_perf_tiles", {16'd0, perf_tiles}, 32'd3);
    exp_done++;
    pulse_start(8'd0, 8'd1);
    check("t6_perf_cleared", perf_stall | {16'd0, perf_tiles}, 32'd0);
    tick();
`endif

    // zero-size configuration
    exp_done++;
    pulse_start(8'd0, 8'd4);
    check("t3_done_next_cycle", {30'd0, done, busy}, 32'd2);
    tick();
    check("t3_idle_after", {29'd0, done, input_re, output_we}, 32'd0);

    // reset in tile 2 WAIT_RD aborts the run
    exp_rd.push_back(16'd0); exp_rd.push_back(16'd1); exp_rd.push_back(16'd2);
    exp_wr.push_back(16'd0); exp_wr.push_back(16'd1);
    pulse_start(8'd3, 8'd2);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (input_re && input_addr == 16'd2) seen = 1'b1;
      else tick();
    end
    if (!seen) fail_now("t4_fetch_tile2");
    tick();
    rst = 1'b1;
    tick();
    check("t4_abort_ctrl", {27'd0, busy, done, input_re, output_we, cap_en}, 32'd0);
    check("t4_abort_tile_xy", {16'd0, tile_x, tile_y}, 32'd0);
    rst = 1'b0;
    push_run(1);
    pulse_start(8'd1, 8'd1);
    wait_done(bc);
    check("t4_restart_busy", bc, 32'd4);

    // long-latency instance with wrapping base
    tick();
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    re_c = -1; cap_c = -1; we_c = -1;
    for (int i = 0; i < 40; i++) begin
      if (input_re5 && re_c < 0) begin
        re_c = i;
        check("t5_in_addr", {16'd0, input_addr5}, 32'hFFFF);
      end
      if (cap_en5 && cap_c < 0) cap_c = i;
      if (output_we5 && we_c < 0) begin
        we_c = i;
        check("t5_out_addr", {16'd0, output_addr5}, 32'h1234);
      end
      if (done5) break;
      tick();
    end
    check("t5_re_cycle", re_c, 32'd0);
    check("t5_cap_after_re", cap_c - re_c, 32'd5);
    check("t5_we_after_cap", we_c - cap_c, 32'd1);

    tick(); tick();
    check("sb_reads_left", exp_rd.size(), 32'd0);
    check("sb_writes_left", exp_wr.size(), 32'd0);
    check("sb_done_left", exp_done, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
